spike_arbiter_fifo: RTL

SPIKE_ARBITER_FIFO -- requirements
Module: spike_arbiter_fifo

---
 rtl/spike_arbiter_fifo.sv | 126 ++++++++++++
 1 files changed

// File: rtl/spike_arbiter_fifo.sv
// spike_arbiter_fifo: synchronizes N_SYN spike inputs, detects rising edges,
// round-robin arbitrates pending spikes into a DEPTH-entry event FIFO.
// Ports: clk, rst_n (async, active low), spk_in[N_SYN] (async levels),
//        ev_valid/ev_idx/ev_ready (head-event handshake), fifo_full,
//        drop_cnt[7:0] (lost-spike count, only with SPIKE_DROP_CNT_EN).
// Optional feature macro: SPIKE_DROP_CNT_EN.
module spike_arbiter_fifo #(
   parameter int N_SYN = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_SYN-1:0]         spk_in,
   output logic                     ev_valid,
   output logic [$clog2(N_SYN)-1:0] ev_idx,
   input  logic                     ev_ready,
   output logic                     fifo_full
`ifdef SPIKE_DROP_CNT_EN
   ,
   output logic [7:0]               drop_cnt
`endif
);

   localparam int IW = $clog2(N_SYN);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);
   localparam logic [IW-1:0] LAST = IW'(N_SYN - 1);
   localparam logic [OW-1:0] FULL = OW'(DEPTH);

   logic [N_SYN-1:0] r_s1;
   logic [N_SYN-1:0] r_s2;
   logic [N_SYN-1:0] r_s3;
   logic [N_SYN-1:0] r_pend;
   logic [IW-1:0]    r_rr;
   logic [IW-1:0]    r_mem [DEPTH];
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [OW-1:0]    r_occ;

   logic [N_SYN-1:0] w_edge;
   logic [N_SYN-1:0] w_gnt_oh;
   logic [IW-1:0]    w_gnt_idx;
   logic             w_push;
   logic             w_pop;

   assign w_edge   = r_s2 & ~r_s3;
   // Push is gated by the registered occupancy only; a same-cycle pop
   // does not make room.
   assign w_push   = (|r_pend) && (r_occ < FULL);
   assign w_pop    = ev_valid & ev_ready;
   assign w_gnt_oh = w_push ? (N_SYN'(1) << w_gnt_idx) : '0;

   // First loop picks the lowest pending bit overall (wrap case); the
   // second overrides it with the lowest pending bit at or above r_rr.
   always_comb begin
      w_gnt_idx = '0;
      for (int i = N_SYN - 1; i >= 0; i--) begin
         if (r_pend[i]) w_gnt_idx = IW'(i);
      end
      for (int i = N_SYN - 1; i >= 0; i--) begin
         if (r_pend[i] && (IW'(i) >= r_rr)) w_gnt_idx = IW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_s3   <= '0;
         r_pend <= '0;
         r_rr   <= '0;
         r_wp   <= '0;
         r_rp   <= '0;
         r_occ  <= '0;
      end else begin
         r_s1   <= spk_in;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         // A new edge on a just-granted bit keeps it pending.
         r_pend <= (r_pend & ~w_gnt_oh) | w_edge;
         if (w_push) begin
            r_rr <= (w_gnt_idx == LAST) ? '0 : w_gnt_idx + 1'b1;
            r_wp <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_push && !w_pop) r_occ <= r_occ + 1'b1;
         else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wp] <= w_gnt_idx;
      end
   end

   assign ev_valid  = (r_occ != '0);
   assign ev_idx    = ev_valid ? r_mem[r_rp] : '0;
   assign fifo_full = (r_occ == FULL);

`ifdef SPIKE_DROP_CNT_EN
   logic [N_SYN-1:0] w_drop;
   logic [8:0]       w_dsum;
   logic [7:0]       r_drop;

   // Edge on a bit already pending and not cleared by this cycle's grant.
   assign w_drop = w_edge & r_pend & ~w_gnt_oh;

   always_comb begin
      w_dsum = {1'b0, r_drop};
      for (int i = 0; i < N_SYN; i++) begin
         w_dsum = w_dsum + {8'd0, w_drop[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_drop <= '0;
      else        r_drop <= w_dsum[8] ? 8'hFF : w_dsum[7:0];
   end

   assign drop_cnt = r_drop;
`endif

endmodule
